load_store_unit: RTL
====================

# load_store_unit

Data-memory access stage for the multicycle RV32I core; sits directly downstream of the control unit's MEM_RD/MEM_WR states. It converts a load/store request (ALU-computed address, rs2 data, funct3) into a word-aligned, byte-enabled memory transaction with a grant/response handshake and variable latency. It returns sign- or zero-extended load data, and reports misalignment, illegal width and timeout as a fault. The control unit holds its memory state until `done`.

## Interface
- `TIMEOUT`, 255: cycles spent in ISSUE+WAIT_R before a watchdog fault; range 1..65535.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset: asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req_valid`  in  1  access request, sampled only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width field: LB/LH/LW/LBU/LHU, or SB/SH/SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (rs2).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  valid with `done`: the access was aborted.
- `rdata`  out  32  extended load result; holds its value until the next successful load.
- `mem_req`  out  1  memory request, held until `mem_gnt`.
- `mem_we`  out  1  write strobe qualifier.
- `mem_addr`  out  32  `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted in the same cycle.
- `mem_rvalid`  in  1  read data valid; at least one cycle after the grant.
- `mem_rdata`  in  32  raw read word.

## Operation
- States: IDLE, ISSUE, WAIT_R, DONE.
- IDLE, `req_valid`=1, legal and aligned access:
  - Latch addr, funct3, write flag and wdata.
  - Clear the watchdog counter.
  - Go to ISSUE.
- IDLE, `req_valid`=1, illegal or misaligned access:
  - Illegal: load funct3 ∈ {011,110,111}; store funct3 ≥ 011.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Set the fault flag and go to DONE. No memory transaction is issued.
- ISSUE drives `mem_req`=1.
  - On `mem_gnt`: a store goes to DONE; a load goes to WAIT_R.
- WAIT_R: on `mem_rvalid`, capture the extended word into `rdata` and go to DONE.
- Watchdog: the counter increments each cycle in ISSUE/WAIT_R. When it reaches TIMEOUT, drop `mem_req`, set fault and go to DONE. `rdata` is left unchanged.
- DONE: `done`=1, `fault` per flag, then go to IDLE unconditionally.
- The requester must drop `req_valid` the cycle after `done`. A `req_valid` seen in IDLE is always treated as a new request.
- Store lanes:
  - SB: byte replicated ×4, be=`4'b0001<<addr[1:0]`.
  - SH: half replicated ×2, be=`4'b0011<<addr[1:0]`.
  - SW: be=`4'b1111`.
- Load extraction: byte selected by addr[1:0], half selected by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- `mem_we`=`write` only while `mem_req`=1. Stores never touch `rdata`.
- `mem_gnt`/`mem_rvalid` arriving in IDLE or DONE are ignored.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `fault`, `mem_req`, `mem_we`=0; `rdata`, `mem_addr`, `mem_be`, `mem_wdata`=0.
- Reset asserted mid-access drops `mem_req` immediately (asynchronously). A late `mem_rvalid` after release is ignored.
- Memory outputs come from registered fields, not from `req_*` combinationally.
- Minimum latency, counted from the cycle `req_valid` is sampled (cycle 0):
  - Store with `mem_gnt` at cycle 1: `done` at cycle 2.
  - Load with gnt at cycle 1 and rvalid at cycle 2: `done` at cycle 3, `rdata` valid that same cycle.
  - Fault without access: `done`+`fault` at cycle 1.
- Timeout: `done` on cycle TIMEOUT+1 after entering ISSUE.
- `mem_gnt` or `mem_rvalid` in the same cycle the counter reaches TIMEOUT: the handshake wins; no fault.

## Structure
- `DataTypes_pkg` gains:
  - `lsu_state_t` (IDLE, ISSUE, WAIT_R, DONE).
  - `mem_width_t` enum of funct3 encodings (LB..LHU, SB..SW).
- Sub-module `lsu_lane_align`, purely combinational, containing:
  - store replication and byte-enable generation;
  - load byte/half selection and extension;
  - misalignment and legality check.
- The FSM, watchdog and registers stay in `load_store_unit`.

## Test plan
- SB, addr 0x1003, wdata 0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x1000; `done` 1 cycle after gnt, `fault`=0.
- LB, addr 0x2002, `mem_rdata`=0x12F03456 → `rdata`=0xFFFFFFF0. LBU at the same address → 0x000000F0. LHU at 0x2002 → 0x000012F0.
- LW, addr 0x3002 → `done`+`fault` at cycle 1. `mem_req` never asserts; `rdata` is unchanged.
- Load with `mem_gnt` withheld, TIMEOUT=4 → fault+done on the 5th cycle after entering ISSUE; `mem_req` low afterward.
- `rst` pulled low while in WAIT_R, then `mem_rvalid` pulsed after release → state IDLE, `mem_req`=0, no `done`, `rdata`=0.
- Back-to-back SW then LW, `req_valid` dropped one cycle after each `done` → exactly two transactions, correct `be`=1111, both fault-free.

Source files
------------

// File: rtl/DataTypes_pkg.sv
// Shared datapath types for the multicycle RV32I core.
// Load/store unit state codes and access-width encodings.
package DataTypes_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t S_IDLE   = 2'd0;
  localparam lsu_state_t S_ISSUE  = 2'd1;
  localparam lsu_state_t S_WAIT_R = 2'd2;
  localparam lsu_state_t S_DONE   = 2'd3;

  // {write, funct3}: loads and stores share funct3 values
  typedef enum logic [3:0] {
    MW_LB  = 4'b0000,
    MW_LH  = 4'b0001,
    MW_LW  = 4'b0010,
    MW_LBU = 4'b0100,
    MW_LHU = 4'b0101,
    MW_SB  = 4'b1000,
    MW_SH  = 4'b1001,
    MW_SW  = 4'b1010
  } mem_width_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: store replication,
// byte enables, legality/alignment checks and load extension.
module lsu_lane_align
  import DataTypes_pkg::*;
(
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_ok,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  mem_width_t  w_kind;
  mem_width_t  w_ld_kind;
  logic        w_legal;
  logic        w_aligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_kind    = mem_width_t'({i_write, i_funct3});
  assign w_ld_kind = mem_width_t'({1'b0, i_ld_funct3});

  always_comb begin
    w_legal   = 1'b1;
    w_aligned = 1'b1;
    o_be      = 4'b0000;
    o_wdata   = i_wdata;
    unique case (w_kind)
      MW_LB, MW_LBU, MW_SB: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MW_LH, MW_LHU, MW_SH: begin
        w_aligned = ~i_off[0];
        o_be      = 4'b0011 << i_off;
        o_wdata   = {2{i_wdata[15:0]}};
      end
      MW_LW, MW_SW: begin
        w_aligned = (i_off == 2'b00);
        o_be      = 4'b1111;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign o_ok = w_legal & w_aligned;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_ld_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_ldata = i_rdata;
    unique case (w_ld_kind)
      MW_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
      MW_LH:   o_ldata = {{16{w_half[15]}}, w_half};
      MW_LBU:  o_ldata = {24'd0, w_byte};
      MW_LHU:  o_ldata = {16'd0, w_half};
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: request latch, grant/response handshake,
// watchdog and load result register for the multicycle RV32I core.
module load_store_unit
  import DataTypes_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // one spare bit: a grant at the limit still counts once in WAIT_R
  localparam logic [16:0] TO = 17'(TIMEOUT);

  lsu_state_t  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic        r_write;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_fault;
  logic [31:0] r_rdata;
  logic [16:0] r_cnt;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_ok;
  logic [31:0] w_ldata;
  logic        w_tmo;

  lsu_lane_align u_align (
    .i_write     (req_write),
    .i_funct3    (req_funct3),
    .i_off       (req_addr[1:0]),
    .i_wdata     (req_wdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_ok        (w_ok),
    .i_ld_funct3 (r_f3),
    .i_ld_off    (r_addr[1:0]),
    .i_rdata     (mem_rdata),
    .o_ldata     (w_ldata)
  );

  assign w_tmo = (r_cnt >= TO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_f3    <= '0;
      r_write <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_fault <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_fault <= ~w_ok;
            r_cnt   <= '0;
            if (w_ok) begin
              r_addr  <= req_addr;
              r_f3    <= req_funct3;
              r_write <= req_write;
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 17'd1;
          if (mem_gnt) begin
            r_state <= r_write ? S_DONE : S_WAIT_R;
          end else if (w_tmo) begin
            r_fault <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_WAIT_R: begin
          r_cnt <= r_cnt + 17'd1;
          if (mem_rvalid) begin
            r_rdata <= w_ldata;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            r_fault <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign fault     = done & r_fault;
  assign rdata     = r_rdata;
  assign mem_req   = (r_state == S_ISSUE);
  assign mem_we    = mem_req & r_write;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

endmodule
